// File: rtl/cipher_stream_receiver.sv
// Serial frame receiver that strips a repeating XOR key and emits plaintext bytes.
// Frames are delimited by start/end flags; malformed frames raise a one-cycle error pulse.
module cipher_stream_receiver #(
  parameter int KEY_SIZE = 32,
  parameter int MSG_SIZE = 512
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iEn,
  input  logic                      iSerial_in,
  input  logic                      iSerial_start,
  input  logic                      iSerial_end,
  input  logic [KEY_SIZE-1:0]       iKey,
  input  logic                      iKey_load,
  output logic [7:0]                oPlain_byte,
  output logic                      oByte_valid,
  output logic                      oFrame_done,
  output logic                      oFrame_error,
  output logic [$clog2(MSG_SIZE):0] oBit_count
);

  localparam int CW = $clog2(MSG_SIZE) + 1;
  localparam int KW = $clog2(KEY_SIZE);
  localparam logic [CW-1:0] LAST_BIT = CW'(MSG_SIZE - 1);
  localparam logic [KW-1:0] KEY_LAST = KW'(KEY_SIZE - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RECEIVE = 2'd1;
  localparam logic [1:0] S_FLUSH   = 2'd2;

  logic [1:0]          state_q,      state_d;
  logic [KEY_SIZE-1:0] key_q,        key_d;
  logic [7:0]          shift_q,      shift_d;
  logic [7:0]          plain_q,      plain_d;
  logic [CW-1:0]       bit_count_q,  bit_count_d;
  logic [KW-1:0]       key_idx_q,    key_idx_d;
  logic                byte_valid_q, byte_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_err_q,  frame_err_d;

  logic          dec_bit;
  logic          dec_bit0;
  logic [KW-1:0] key_idx_next;
  logic          byte_full;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves one unassigned (no latches).
    state_d      = state_q;
    key_d        = key_q;
    shift_d      = shift_q;
    plain_d      = plain_q;
    bit_count_d  = bit_count_q;
    key_idx_d    = key_idx_q;
    byte_valid_d = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    dec_bit      = iSerial_in ^ key_q[KEY_LAST - key_idx_q];
    // Bit 0 of a frame always uses the key MSB, whatever the stale index says.
    dec_bit0     = iSerial_in ^ key_q[KEY_SIZE-1];
    key_idx_next = (key_idx_q == KEY_LAST) ? '0 : key_idx_q + KW'(1);
    byte_full    = (bit_count_q[2:0] == 3'd7);

    if (iEn) begin
      case (state_q)
        S_IDLE: begin
          if (iKey_load) key_d = iKey;
          if (iSerial_start && iSerial_end) begin
            frame_err_d = 1'b1;
          end else if (iSerial_start) begin
            shift_d     = {7'd0, dec_bit0};
            bit_count_d = CW'(1);
            key_idx_d   = KW'(1);
            state_d     = S_RECEIVE;
          end
        end

        S_RECEIVE: begin
          if (iSerial_start) begin
            frame_err_d = 1'b1;
            shift_d     = {7'd0, dec_bit0};
            bit_count_d = CW'(1);
            key_idx_d   = KW'(1);
          end else begin
            shift_d     = {shift_q[6:0], dec_bit};
            bit_count_d = bit_count_q + CW'(1);
            key_idx_d   = key_idx_next;
            if (iSerial_end && (bit_count_q != LAST_BIT)) begin
              frame_err_d = 1'b1;
              shift_d     = '0;
              state_d     = S_IDLE;
            end else begin
              if (byte_full) begin
                byte_valid_d = 1'b1;
                plain_d      = {shift_q[6:0], dec_bit};
              end
              if (bit_count_q == LAST_BIT) begin
                if (iSerial_end) begin
                  frame_done_d = 1'b1;
                  state_d      = S_FLUSH;
                end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_IDLE;
                end
              end
            end
          end
        end

        S_FLUSH: state_d = S_IDLE;

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q      <= S_IDLE;
      key_q        <= '0;
      shift_q      <= '0;
      plain_q      <= '0;
      bit_count_q  <= '0;
      key_idx_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      shift_q      <= shift_d;
      plain_q      <= plain_d;
      bit_count_q  <= bit_count_d;
      key_idx_q    <= key_idx_d;
      byte_valid_q <= byte_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign oPlain_byte  = plain_q;
  assign oByte_valid  = byte_valid_q;
  assign oFrame_done  = frame_done_q;
  assign oFrame_error = frame_err_q;
  assign oBit_count   = bit_count_q;

endmodule
